// File: rtl/wb_write_port.sv
// Register-file write port for the MEM/WB stage: selects the writeback data, drops writes to XZR,
// and arbitrates the port between a debug writer and an in-order writeback queue. Optional: WB_PENDING_MASK_EN.
module wb_write_port #(
   parameter int DW    = 64,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rd,
   input  logic          in_regwr,
   input  logic [1:0]    in_sel,
   input  logic [DW-1:0] in_alu,
   input  logic [DW-1:0] in_mem,
   input  logic [DW-1:0] in_pc4,
   input  logic          dbg_wr,
   input  logic [AW-1:0] dbg_rw,
   input  logic [DW-1:0] dbg_data,
   output logic [AW-1:0] RW,
   output logic [DW-1:0] BusW,
   output logic          RegWr,
   output logic [7:0]    wb_count
`ifdef WB_PENDING_MASK_EN
   ,
   output logic [31:0]   pend_mask
`endif
);

   localparam int CW = 3;
   localparam logic [AW-1:0] XZR = AW'(31);

   logic [CW-1:0] count_reg, count_next;
   logic [AW-1:0] q_rd_reg   [DEPTH];
   logic [AW-1:0] q_rd_next  [DEPTH];
   logic [DW-1:0] q_data_reg [DEPTH];
   logic [DW-1:0] q_data_next[DEPTH];
   logic [AW-1:0] shift_rd   [DEPTH];
   logic [DW-1:0] shift_data [DEPTH];

   logic [AW-1:0] rw_reg, rw_next;
   logic [DW-1:0] busw_reg, busw_next;
   logic          regwr_reg, regwr_next;
   logic [7:0]    wb_count_reg, wb_count_next;

   logic          accept, keep, pop, bypass, enq;
   logic [DW-1:0] sel_data;
   logic [CW-1:0] wr_idx;

   assign in_ready = (count_reg < CW'(DEPTH));
   assign accept   = in_valid & in_ready;
   assign keep     = accept & in_regwr & (in_rd != XZR);
   assign pop      = ~dbg_wr & (count_reg != '0);
   assign bypass   = ~dbg_wr & (count_reg == '0) & keep;
   assign enq      = keep & ~bypass;
   // A pop in the same cycle frees the head, so the new entry lands one slot lower.
   assign wr_idx   = count_reg - (pop ? CW'(1) : CW'(0));

   always_comb begin
      case (in_sel)
         2'b01:   sel_data = in_mem;
         2'b10:   sel_data = in_pc4;
         default: sel_data = in_alu;
      endcase
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
         if (gi < DEPTH - 1) begin : g_mid
            assign shift_rd[gi]   = q_rd_reg[gi+1];
            assign shift_data[gi] = q_data_reg[gi+1];
         end else begin : g_tail
            assign shift_rd[gi]   = q_rd_reg[gi];
            assign shift_data[gi] = q_data_reg[gi];
         end
      end
   endgenerate

   always_comb begin
      count_next = count_reg + (enq ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      for (int i = 0; i < DEPTH; i++) begin
         q_rd_next[i]   = pop ? shift_rd[i]   : q_rd_reg[i];
         q_data_next[i] = pop ? shift_data[i] : q_data_reg[i];
         if (enq && (wr_idx == CW'(i))) begin
            q_rd_next[i]   = in_rd;
            q_data_next[i] = sel_data;
         end
      end

      regwr_next    = 1'b0;
      rw_next       = rw_reg;
      busw_next     = busw_reg;
      wb_count_next = wb_count_reg;
      if (dbg_wr) begin
         rw_next    = dbg_rw;
         busw_next  = dbg_data;
         regwr_next = (dbg_rw != XZR);
      end else if (pop) begin
         rw_next       = q_rd_reg[0];
         busw_next     = q_data_reg[0];
         regwr_next    = 1'b1;
         wb_count_next = wb_count_reg + 8'd1;
      end else if (bypass) begin
         rw_next       = in_rd;
         busw_next     = sel_data;
         regwr_next    = 1'b1;
         wb_count_next = wb_count_reg + 8'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_reg    <= '0;
         rw_reg       <= '0;
         busw_reg     <= '0;
         regwr_reg    <= 1'b0;
         wb_count_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_rd_reg[i]   <= '0;
            q_data_reg[i] <= '0;
         end
      end else begin
         count_reg    <= count_next;
         rw_reg       <= rw_next;
         busw_reg     <= busw_next;
         regwr_reg    <= regwr_next;
         wb_count_reg <= wb_count_next;
         for (int i = 0; i < DEPTH; i++) begin
            q_rd_reg[i]   <= q_rd_next[i];
            q_data_reg[i] <= q_data_next[i];
         end
      end
   end

   assign RW       = rw_reg;
   assign BusW     = busw_reg;
   assign RegWr    = regwr_reg;
   assign wb_count = wb_count_reg;

`ifdef WB_PENDING_MASK_EN
   logic [31:0] pend_oh [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
         assign pend_oh[gi] = (CW'(gi) < count_reg) ? (32'd1 << q_rd_reg[gi]) : 32'd0;
      end
   endgenerate

   // Derived from registered queue state, so it moves on the enqueue/pop edge.
   always_comb begin
      pend_mask = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_mask = pend_mask | pend_oh[i];
      end
      pend_mask[31] = 1'b0;
   end
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Bench for wb_write_port: scenario tasks plus a negedge scoreboard monitor for port writes.
module tb_wb_write_port;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int DEPTH = 2;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          in_valid = 1'b0, in_regwr = 1'b0, dbg_wr = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_rd = '0, dbg_rw = '0;
   logic [1:0]    in_sel = '0;
   logic [DW-1:0] in_alu = '0, in_mem = '0, in_pc4 = '0, dbg_data = '0;
   logic [AW-1:0] RW;
   logic [DW-1:0] BusW;
   logic          RegWr;
   logic [7:0]    wb_count;
`ifdef WB_PENDING_MASK_EN
   logic [31:0]   pend_mask;
`endif

   always #5 Clk = ~Clk;

   wb_write_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_regwr(in_regwr), .in_sel(in_sel), .in_alu(in_alu),
      .in_mem(in_mem), .in_pc4(in_pc4), .dbg_wr(dbg_wr), .dbg_rw(dbg_rw),
      .dbg_data(dbg_data), .RW(RW), .BusW(BusW), .RegWr(RegWr), .wb_count(wb_count)
`ifdef WB_PENDING_MASK_EN
      , .pend_mask(pend_mask)
`endif
   );

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   bit            mon_en = 1'b0;
   logic          last_rst = 1'b1, last_dbg = 1'b0;
   logic [AW-1:0] last_rw = '0;
   logic [DW-1:0] last_data = '0;
   logic [7:0]    exp_count = '0;

   function automatic logic [DW-1:0] pick(input logic [1:0] s, input logic [DW-1:0] a,
                                          input logic [DW-1:0] m, input logic [DW-1:0] p);
      if (s == 2'b01) return m;
      if (s == 2'b10) return p;
      return a;
   endfunction

   // Outputs seen here were registered from the inputs sampled one negedge earlier.
   always @(negedge Clk) begin
      if (mon_en) begin
         wr_t e;
         if (last_rst) begin
            sb.delete();
            exp_count = '0;
            n_cmp++;
            if (RegWr !== 1'b0 || wb_count !== 8'd0) begin
               n_err++;
               $display("FAIL mon_reset: RegWr=%b wb_count=%0d, required 0/0", RegWr, wb_count);
            end
         end else if (last_dbg) begin
            n_cmp++;
            if (RW !== last_rw || BusW !== last_data || RegWr !== (last_rw != 5'd31)) begin
               n_err++;
               $display("FAIL mon_dbg: RW=%0d BusW=%h RegWr=%b, required RW=%0d BusW=%h RegWr=%b",
                        RW, BusW, RegWr, last_rw, last_data, (last_rw != 5'd31));
            end
         end else if (RegWr === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL mon_spurious: write RW=%0d BusW=%h with nothing pending", RW, BusW);
            end else begin
               e = sb.pop_front();
               exp_count++;
               if (RW !== e.rd || BusW !== e.data) begin
                  n_err++;
                  $display("FAIL mon_order: RW=%0d BusW=%h, required RW=%0d BusW=%h",
                           RW, BusW, e.rd, e.data);
               end
            end
         end else if (RegWr !== 1'b0 || sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mon_stall: RegWr=%b with %0d pending, required a write", RegWr, sb.size());
         end
         n_cmp++;
         if (in_ready !== (sb.size() < DEPTH)) begin
            n_err++;
            $display("FAIL mon_ready: in_ready=%b, required %b", in_ready, (sb.size() < DEPTH));
         end
         last_rst  = Reset;
         last_dbg  = dbg_wr & ~Reset;
         last_rw   = dbg_rw;
         last_data = dbg_data;
         if (!Reset && in_valid && in_ready && in_regwr && in_rd != 5'd31)
            sb.push_back('{rd: in_rd, data: pick(in_sel, in_alu, in_mem, in_pc4)});
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_regwr = 1'b0; in_rd = '0; in_sel = '0;
      dbg_wr = 1'b0; dbg_rw = '0; dbg_data = '0;
   endtask

   task automatic offer(input logic [AW-1:0] rd, input logic wr, input logic [1:0] s,
                        input logic [DW-1:0] a, input logic [DW-1:0] m, input logic [DW-1:0] p);
      in_valid = 1'b1; in_rd = rd; in_regwr = wr; in_sel = s;
      in_alu = a; in_mem = m; in_pc4 = p;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      idle();
      tick();
      tick();
      mon_en = 1'b1;
      Reset = 1'b0;
      n_cmp++;
      if (RW !== '0 || BusW !== '0 || RegWr !== 1'b0 || wb_count !== 8'd0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: RW=%0d BusW=%h RegWr=%b wb_count=%0d in_ready=%b, required 0/0/0/0/1",
                  RW, BusW, RegWr, wb_count, in_ready);
      end
   endtask

   task automatic test_basic();
      offer(5'd5, 1'b1, 2'b00, 64'h1234, 64'h7777, 64'h8888);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (RegWr !== 1'b1 || RW !== 5'd5 || BusW !== 64'h1234 || wb_count !== 8'd1) begin
         n_err++;
         $display("FAIL basic_latency: RegWr=%b RW=%0d BusW=%h wb_count=%0d, required 1/5/1234/1",
                  RegWr, RW, BusW, wb_count);
      end
      tick();
      n_cmp++;
      if (RegWr !== 1'b0) begin
         n_err++;
         $display("FAIL basic_deassert: RegWr=%b, required 0", RegWr);
      end
   endtask

   task automatic test_filter();
      offer(5'd31, 1'b1, 2'b00, 64'hABCD, 64'h0, 64'h0);
      tick();
      offer(5'd7, 1'b0, 2'b00, 64'hBEEF, 64'h0, 64'h0);
      n_cmp++;
      if (RegWr !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL filter_xzr: RegWr=%b in_ready=%b, required 0/1", RegWr, in_ready);
      end
      tick();
      idle();
      tick();
      n_cmp++;
      if (RegWr !== 1'b0 || wb_count !== 8'd1 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL filter_noregwr: RegWr=%b wb_count=%0d in_ready=%b, required 0/1/1",
                  RegWr, wb_count, in_ready);
      end
   endtask

   task automatic test_dbg_starve();
      dbg_wr = 1'b1; dbg_rw = 5'd3; dbg_data = 64'hAA;
      offer(5'd1, 1'b1, 2'b01, 64'hD1, 64'h11, 64'hE1);
      tick();
      offer(5'd2, 1'b1, 2'b10, 64'hD2, 64'hE2, 64'h44);
      n_cmp++;
      if (RegWr !== 1'b1 || RW !== 5'd3 || BusW !== 64'hAA || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL starve_dbg: RegWr=%b RW=%0d BusW=%h in_ready=%b, required 1/3/aa/1",
                  RegWr, RW, BusW, in_ready);
      end
      tick();
`ifdef WB_PENDING_MASK_EN
      n_cmp++;
      if (pend_mask !== 32'h6) begin
         n_err++;
         $display("FAIL pend_two: pend_mask=%h, required 00000006", pend_mask);
      end
`endif
      offer(5'd4, 1'b1, 2'b00, 64'h99, 64'hE3, 64'hE4);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL starve_full: in_ready=%b, required 0", in_ready);
         end
         tick();
      end
      dbg_wr = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b0 || wb_count !== 8'd1) begin
         n_err++;
         $display("FAIL starve_held: in_ready=%b wb_count=%0d, required 0/1", in_ready, wb_count);
      end
      tick();
      n_cmp++;
      if (RegWr !== 1'b1 || RW !== 5'd1 || BusW !== 64'h11 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL drain_r1: RegWr=%b RW=%0d BusW=%h in_ready=%b, required 1/1/11/1",
                  RegWr, RW, BusW, in_ready);
      end
`ifdef WB_PENDING_MASK_EN
      n_cmp++;
      if (pend_mask !== 32'h4) begin
         n_err++;
         $display("FAIL pend_one: pend_mask=%h, required 00000004", pend_mask);
      end
`endif
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (RegWr !== 1'b1 || RW !== 5'd2 || BusW !== 64'h44) begin
         n_err++;
         $display("FAIL drain_r2: RegWr=%b RW=%0d BusW=%h, required 1/2/44", RegWr, RW, BusW);
      end
`ifdef WB_PENDING_MASK_EN
      n_cmp++;
      if (pend_mask !== 32'h10) begin
         n_err++;
         $display("FAIL pend_r4: pend_mask=%h, required 00000010", pend_mask);
      end
`endif
      tick();
      n_cmp++;
      if (RegWr !== 1'b1 || RW !== 5'd4 || BusW !== 64'h99 || wb_count !== 8'd4) begin
         n_err++;
         $display("FAIL drain_r4: RegWr=%b RW=%0d BusW=%h wb_count=%0d, required 1/4/99/4",
                  RegWr, RW, BusW, wb_count);
      end
`ifdef WB_PENDING_MASK_EN
      n_cmp++;
      if (pend_mask !== 32'h0) begin
         n_err++;
         $display("FAIL pend_clear: pend_mask=%h, required 00000000", pend_mask);
      end
`endif
      tick();
   endtask

   task automatic test_sel_reserved();
      offer(5'd9, 1'b1, 2'b11, 64'h55, 64'h66, 64'h77);
      tick();
      idle();
      n_cmp++;
      if (RegWr !== 1'b1 || RW !== 5'd9 || BusW !== 64'h55) begin
         n_err++;
         $display("FAIL sel_reserved: RegWr=%b RW=%0d BusW=%h, required 1/9/55", RegWr, RW, BusW);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      dbg_wr = 1'b1; dbg_rw = 5'd12; dbg_data = 64'hCC;
      offer(5'd10, 1'b1, 2'b00, 64'hA0, 64'h0, 64'h0);
      tick();
      offer(5'd11, 1'b1, 2'b00, 64'hA1, 64'h0, 64'h0);
      tick();
      idle();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (RegWr !== 1'b0 || wb_count !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: RegWr=%b wb_count=%0d in_ready=%b, required 0/0/1",
                     RegWr, wb_count, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 256; i++) begin
         offer(AW'(i % 31), 1'b1, 2'b00, {$urandom, $urandom}, 64'h0, 64'h0);
         tick();
         if (i == 254) begin
            n_cmp++;
            if (wb_count !== 8'hFF) begin
               n_err++;
               $display("FAIL wrap_255: wb_count=%0d, required 255", wb_count);
            end
         end
      end
      idle();
      n_cmp++;
      if (wb_count !== 8'd0) begin
         n_err++;
         $display("FAIL wrap_0: wb_count=%0d, required 0", wb_count);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         dbg_wr   = ($urandom_range(3) == 0);
         dbg_rw   = ($urandom_range(7) == 0) ? 5'd31 : AW'($urandom_range(30));
         dbg_data = {$urandom, $urandom};
         offer(AW'($urandom_range(31)), ($urandom_range(9) != 0), 2'($urandom_range(3)),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         in_valid = ($urandom_range(2) != 0);
         tick();
      end
      idle();
      for (int k = 0; k < 6; k++) tick();
      @(negedge Clk);
      #1;
      n_cmp++;
      if (sb.size() != 0 || wb_count !== exp_count) begin
         n_err++;
         $display("FAIL b2b_drain: pending=%0d wb_count=%0d, required 0 pending wb_count=%0d",
                  sb.size(), wb_count, exp_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_dbg_starve();
      test_sel_reserved();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
